cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss handler and write-through engine between the CPU and the direct-mapped byte cache.
//  Accepts CPU read/write requests and checks the cache's combinational hit/data result.
//  On a read miss it fetches the byte from main memory over a req/ack handshake, fills the cache and returns the data.
//  On a write it writes main memory, then updates the cache. Also keeps saturating hit/miss statistics.
// PARAMETERS
//  ADDR_W   16   address width (cache tag = ADDR_W-1:7, index = 6:0)
//  DATA_W   8    data width
//  TIMEOUT  255  max cycles spent in MEM_RD/MEM_WR waiting for mem_ack before abort (>=1)
// PORTS
//  clk_1        in   1       sole clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  cpu_req      in   1       CPU request; level, held until cpu_ack seen
//  cpu_wr       in   1       1=write, 0=read; valid with cpu_req
//  cpu_addr     in   ADDR_W  request address
//  cpu_wdata    in   DATA_W  write data
//  cpu_rdata    out  DATA_W  read data; valid while cpu_ack=1
//  cpu_ack      out  1       one-cycle completion pulse
//  cpu_err      out  1       high with cpu_ack when the memory access timed out
//  cache_addr   out  ADDR_W  lookup/fill address to cache (latched request address)
//  cache_hit    in   1       cache tag match for cache_addr (combinational)
//  cache_rdata  in   DATA_W  cache data for cache_addr (combinational)
//  cache_we     out  1       one-cycle fill/update strobe
//  cache_wdata  out  DATA_W  fill/update data
//  mem_req      out  1       memory request, held until mem_ack or timeout
//  mem_wr       out  1       1=write, 0=read; stable while mem_req=1
//  mem_addr     out  ADDR_W  memory address, stable while mem_req=1
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data, sampled when mem_ack=1
//  mem_ack      in   1       memory completion, one cycle
//  hit_cnt      out  16      read hits, saturates at 16'hFFFF
//  miss_cnt     out  16      read misses, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including counters, cpu_rdata and the latched address/data.
//   A reset mid-transaction abandons it: mem_req=0 from the next edge, no cpu_ack, no cache_we.
//  IDLE:   cpu_req=1 -> latch cpu_wr/cpu_addr/cpu_wdata, go LOOKUP. cache_addr = latched address in all states.
//  LOOKUP: one cycle.
//   Read and cache_hit: cpu_rdata<=cache_rdata, hit_cnt++, go DONE.
//   Read and miss: miss_cnt++, go MEM_RD.
//   Write: go MEM_WR; the counters are not touched.
//  MEM_RD: mem_req=1, mem_wr=0, mem_addr=latched address.
//   On mem_ack: capture mem_rdata into cpu_rdata and cache_wdata, go FILL.
//  MEM_WR: mem_req=1, mem_wr=1, mem_wdata=latched data. On mem_ack: cache_wdata<=latched data, go FILL.
//  FILL:   cache_we=1 for exactly one cycle; go DONE. A write always allocates, setting the tag in the cache.
//  DONE:   cpu_ack=1 for one cycle; go IDLE.
//   If cpu_req is still 1 in the next IDLE cycle, it is taken as a new request (back-to-back is legal).
//  Timeout: a cycle counter is cleared on entry to MEM_RD/MEM_WR.
//   If TIMEOUT cycles pass without mem_ack, mem_req drops at the next edge.
//   FILL is skipped and the FSM goes to DONE with cpu_err=1 and cpu_rdata=all-ones.
//   If mem_ack arrives in the expiry cycle itself, the ack wins: normal completion, no error.
//  mem_ack outside MEM_RD/MEM_WR is ignored. cpu_req changes outside IDLE are ignored.
//  Latency: request sampled in IDLE at edge N (counts from that edge).
//   Read hit: cpu_ack at cycle N+2.
//   Miss or write with mem_ack in the m-th MEM_* cycle: cpu_ack at N+3+m.
//  Counters: 16-bit unsigned, no wrap; they hold at 16'hFFFF.
//  cache_we is 0 in every state except FILL. mem_req is 0 in every state except MEM_RD/MEM_WR.
// TESTING
//  1 Read hit: cache model holds 0x0081=0x69; req rd 0x0081 -> ack 2 cycles later, rdata=0x69, hit_cnt=1, no mem_req.
//  2 Read miss: mem returns 0x3C after 3 cycles for 0x1234 -> one cache_we with wdata=0x3C, ack at N+6, rdata=0x3C, miss_cnt=1.
//  3 Write 0xA5 to 0x0200 -> mem_req with mem_wr=1 and wdata=0xA5.
//    After ack, one cache_we with wdata=0xA5; a following read of 0x0200 hits and returns 0xA5.
//  4 Timeout, TIMEOUT=4, memory never acks -> mem_req high 4 cycles.
//    Then ack with cpu_err=1 and rdata=0xFF; no cache_we. Repeat with mem_ack on cycle 4 -> err=0.
//  5 Reset during MEM_RD -> mem_req=0 next cycle, no ack, counters=0; the next request completes normally.
//  6 Preload hit_cnt to 0xFFFE, then 3 hits -> hit_cnt=0xFFFF (saturated). Back-to-back req held high -> two acks 3 cycles apart.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// Bus bundles for the cache refill controller: CPU request port,
// cache lookup/fill port and main-memory req/ack port.
// In each bundle the master drives the request side.

interface cpu_bus_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;

   modport master (output req, wr, addr, wdata, input  rdata, ack, err);
   modport slave  (input  req, wr, addr, wdata, output rdata, ack, err);
endinterface

interface cache_port_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              hit;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [DATA_W-1:0] wdata;

   modport master (output addr, we, wdata, input  hit, rdata);
   modport slave  (input  addr, we, wdata, output hit, rdata);
endinterface

interface mem_bus_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, wr, addr, wdata, input  rdata, ack);
   modport slave  (input  req, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss handler and write-through engine between the CPU and a direct-mapped
// byte cache. Read hits complete from the cache; read misses fetch from main
// memory and fill the cache; writes go to memory first and then allocate in
// the cache. A bounded wait on mem_ack turns a dead memory into an error
// completion. Saturating read hit/miss counters are kept.

module cache_refill_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic         clk_1,
   input  logic         rst,
   cpu_bus_if.slave     cpu,
   cache_port_if.master cache,
   mem_bus_if.master    mem,
   output logic [15:0]  hit_cnt,
   output logic [15:0]  miss_cnt
);

   // The wait counter only has to reach TIMEOUT-1 (cycle index of the last
   // allowed MEM_* cycle), so log2(TIMEOUT) bits are enough.
   localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      FILL,
      DONE
   } state_t;

   state_t state_q, state_d;

   // Request latched in IDLE; everything downstream works from these copies.
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] fill_data_q;
   logic              err_q;
   logic [TMO_W-1:0]  tmo_q;

   logic              mem_busy;
   logic              tmo_expired;
   logic              count_hit;
   logic              count_miss;
   logic [15:0]       hit_cnt_d;
   logic [15:0]       miss_cnt_d;

   logic              ack_c;
   logic              we_c;
   logic              mem_req_c;
   logic              mem_wr_c;

   assign mem_busy    = (state_q == MEM_RD) || (state_q == MEM_WR);
   // An ack in the expiry cycle wins, so expiry requires mem_ack low.
   assign tmo_expired = mem_busy && !mem.ack && (tmo_q == TMO_LAST);
   assign count_hit   = (state_q == LOOKUP) && !wr_q &&  cache.hit;
   assign count_miss  = (state_q == LOOKUP) && !wr_q && !cache.hit;

   // State register.
   always_ff @(posedge clk_1) begin
      // NOTE: every clocked assignment is non-blocking so all registers update
      // from the same pre-edge values regardless of statement order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and Moore strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d   = state_q;
      ack_c     = 1'b0;
      we_c      = 1'b0;
      mem_req_c = 1'b0;
      mem_wr_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu.req) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (wr_q)           state_d = MEM_WR;
            else if (cache.hit) state_d = DONE;
            else                state_d = MEM_RD;
         end
         MEM_RD: begin
            mem_req_c = 1'b1;
            if (mem.ack)          state_d = FILL;
            else if (tmo_expired) state_d = DONE;
         end
         MEM_WR: begin
            mem_req_c = 1'b1;
            mem_wr_c  = 1'b1;
            if (mem.ack)          state_d = FILL;
            else if (tmo_expired) state_d = DONE;
         end
         FILL: begin
            we_c    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            ack_c   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Saturating next values for the statistics counters.
   always_comb begin
      hit_cnt_d  = hit_cnt;
      miss_cnt_d = miss_cnt;
      if (count_hit  && (hit_cnt  != 16'hFFFF)) hit_cnt_d  = hit_cnt  + 16'd1;
      if (count_miss && (miss_cnt != 16'hFFFF)) miss_cnt_d = miss_cnt + 16'd1;
   end

   // Request latch, read data, fill data, error flag and wait counter.
   always_ff @(posedge clk_1) begin
      if (rst) begin
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         fill_data_q <= '0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
      end else begin
         if ((state_q == IDLE) && cpu.req) begin
            wr_q    <= cpu.wr;
            addr_q  <= cpu.addr;
            wdata_q <= cpu.wdata;
            err_q   <= 1'b0;
         end

         if (count_hit) rdata_q <= cache.rdata;

         if (mem_busy && mem.ack) begin
            if (state_q == MEM_RD) begin
               rdata_q     <= mem.rdata;
               fill_data_q <= mem.rdata;
            end else begin
               fill_data_q <= wdata_q;
            end
         end else if (tmo_expired) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
         end

         // Cleared outside MEM_*, so it starts from zero on every entry.
         if (mem_busy) tmo_q <= tmo_q + 1'b1;
         else          tmo_q <= '0;
      end
   end

   // Statistics counters, reloaded every cycle from their next values.
   always_ff @(posedge clk_1) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         hit_cnt  <= hit_cnt_d;
         miss_cnt <= miss_cnt_d;
      end
   end

   assign cpu.rdata   = rdata_q;
   assign cpu.ack     = ack_c;
   assign cpu.err     = ack_c && err_q;

   assign cache.addr  = addr_q;
   assign cache.we    = we_c;
   assign cache.wdata = fill_data_q;

   assign mem.req     = mem_req_c;
   assign mem.wr      = mem_wr_c;
   assign mem.addr    = addr_q;
   assign mem.wdata   = wdata_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a direct-mapped cache model, a memory
// responder acking after a programmable number of cycles, and a linear test
// sequence with hand-computed expectations.

module tb_cache_refill_ctrl;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 4;

   logic        clk_1 = 1'b0;
   logic        rst;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   cpu_bus_if    #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu   ();
   cache_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cache ();
   mem_bus_if    #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem   ();

   cache_refill_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_1   (clk_1),
      .rst     (rst),
      .cpu     (cpu),
      .cache   (cache),
      .mem     (mem),
      .hit_cnt (hit_cnt),
      .miss_cnt(miss_cnt)
   );

   always #5 clk_1 = ~clk_1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Direct-mapped cache model: index = addr[6:0], tag = addr[15:7].
   bit          c_valid [128];
   logic [8:0]  c_tag   [128];
   logic [7:0]  c_data  [128];
   logic        pre_en   = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;

   always @(posedge clk_1) begin
      if (cache.we) begin
         c_valid[cache.addr[6:0]] <= 1'b1;
         c_tag[cache.addr[6:0]]   <= cache.addr[15:7];
         c_data[cache.addr[6:0]]  <= cache.wdata;
      end else if (pre_en) begin
         c_valid[pre_addr[6:0]] <= 1'b1;
         c_tag[pre_addr[6:0]]   <= pre_addr[15:7];
         c_data[pre_addr[6:0]]  <= pre_data;
      end
   end

   assign cache.hit   = c_valid[cache.addr[6:0]] && (c_tag[cache.addr[6:0]] == cache.addr[15:7]);
   assign cache.rdata = c_data[cache.addr[6:0]];

   // Event monitor, sampling DUT strobes at each active edge.
   int         cyc        = 0;
   int         we_cnt     = 0;
   int         ack_cnt    = 0;
   int         req_cycles = 0;
   logic [7:0] last_we_data = '0;

   always @(posedge clk_1) begin
      cyc <= cyc + 1;
      if (cache.we) begin
         we_cnt       <= we_cnt + 1;
         last_we_data <= cache.wdata;
      end
      if (cpu.ack) ack_cnt    <= ack_cnt + 1;
      if (mem.req) req_cycles <= req_cycles + 1;
   end

   // Memory responder: acks in the ack_at-th cycle of a request (0 = never).
   int          ack_at   = 0;
   logic [7:0]  mem_data = '0;
   int          mem_cnt  = 0;
   logic [15:0] seen_addr  = '0;
   logic        seen_wr    = 1'b0;
   logic [7:0]  seen_wdata = '0;

   initial begin
      mem.ack   = 1'b0;
      mem.rdata = '0;
      forever begin
         @(negedge clk_1);
         if (mem.req) mem_cnt = mem_cnt + 1;
         else         mem_cnt = 0;
         mem.rdata = mem_data;
         if (mem.req && (ack_at != 0) && (mem_cnt == ack_at)) begin
            mem.ack    = 1'b1;
            seen_addr  = mem.addr;
            seen_wr    = mem.wr;
            seen_wdata = mem.wdata;
         end else begin
            mem.ack = 1'b0;
         end
      end
   end

   // Issue one request and wait (bounded) for its ack. lat counts edges from
   // the edge that sampled the request to the edge that samples cpu_ack.
   task automatic do_req(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [7:0] wdata, output int lat,
                         output logic [7:0] rdata, output logic err);
      int  n;
      bit  seen;
      seen  = 1'b0;
      lat   = -1;
      rdata = '0;
      err   = 1'b0;
      @(negedge clk_1);
      cpu.req   = 1'b1;
      cpu.wr    = wr;
      cpu.addr  = addr;
      cpu.wdata = wdata;
      @(negedge clk_1);
      n = cyc;
      for (int i = 0; i < 40; i++) begin
         if (cpu.ack) begin
            seen  = 1'b1;
            lat   = cyc + 1 - n;
            rdata = cpu.rdata;
            err   = cpu.err;
            break;
         end
         @(negedge clk_1);
      end
      cpu.req = 1'b0;
      check({tag, "_ack_seen"}, 32'(seen), 32'd1);
   endtask

   int         lat;
   logic [7:0] rd;
   logic       er;
   int         we0, req0, ack0;
   int         first_ack, second_ack;

   initial begin
      rst       = 1'b1;
      cpu.req   = 1'b0;
      cpu.wr    = 1'b0;
      cpu.addr  = '0;
      cpu.wdata = '0;

      // Reset state.
      repeat (3) @(posedge clk_1);
      @(negedge clk_1);
      check("rst_hit_cnt",  hit_cnt,    0);
      check("rst_miss_cnt", miss_cnt,   0);
      check("rst_ack",      cpu.ack,    0);
      check("rst_err",      cpu.err,    0);
      check("rst_rdata",    cpu.rdata,  0);
      check("rst_mem_req",  mem.req,    0);
      check("rst_cache_we", cache.we,   0);
      check("rst_cache_addr", cache.addr, 0);
      rst = 1'b0;

      // Preload the cache model with 0x0081 = 0x69.
      pre_en   = 1'b1;
      pre_addr = 16'h0081;
      pre_data = 8'h69;
      @(negedge clk_1);
      pre_en = 1'b0;

      // 1: read hit.
      req0 = req_cycles;
      do_req("hit", 1'b0, 16'h0081, 8'h00, lat, rd, er);
      check("hit_latency",  lat, 2);
      check("hit_rdata",    rd, 8'h69);
      check("hit_err",      er, 0);
      check("hit_hit_cnt",  hit_cnt, 1);
      check("hit_miss_cnt", miss_cnt, 0);
      check("hit_no_memreq", req_cycles - req0, 0);

      // 2: read miss, memory acks in the 3rd cycle with 0x3C.
      ack_at   = 3;
      mem_data = 8'h3C;
      we0  = we_cnt;
      req0 = req_cycles;
      do_req("miss", 1'b0, 16'h1234, 8'h00, lat, rd, er);
      check("miss_latency",  lat, 6);
      check("miss_rdata",    rd, 8'h3C);
      check("miss_err",      er, 0);
      check("miss_miss_cnt", miss_cnt, 1);
      check("miss_hit_cnt",  hit_cnt, 1);
      check("miss_we_pulses", we_cnt - we0, 1);
      check("miss_we_data",  last_we_data, 8'h3C);
      check("miss_req_cycles", req_cycles - req0, 3);
      check("miss_mem_addr", seen_addr, 16'h1234);
      check("miss_mem_wr",   seen_wr, 0);
      do_req("refetch", 1'b0, 16'h1234, 8'h00, lat, rd, er);
      check("refetch_latency", lat, 2);
      check("refetch_rdata",   rd, 8'h3C);
      check("refetch_hit_cnt", hit_cnt, 2);

      // 3: write-through with allocate, then read back as a hit.
      ack_at = 2;
      we0 = we_cnt;
      do_req("write", 1'b1, 16'h0200, 8'hA5, lat, rd, er);
      check("write_latency",  lat, 5);
      check("write_err",      er, 0);
      check("write_mem_wr",   seen_wr, 1);
      check("write_mem_wdata", seen_wdata, 8'hA5);
      check("write_mem_addr", seen_addr, 16'h0200);
      check("write_we_pulses", we_cnt - we0, 1);
      check("write_we_data",  last_we_data, 8'hA5);
      check("write_hit_cnt",  hit_cnt, 2);
      check("write_miss_cnt", miss_cnt, 1);
      do_req("wr_readback", 1'b0, 16'h0200, 8'h00, lat, rd, er);
      check("wr_readback_latency", lat, 2);
      check("wr_readback_rdata",   rd, 8'hA5);
      check("wr_readback_hit_cnt", hit_cnt, 3);

      // 4a: memory never acks -> timeout after TIMEOUT request cycles.
      ack_at = 0;
      we0  = we_cnt;
      req0 = req_cycles;
      do_req("tmo", 1'b0, 16'h4000, 8'h00, lat, rd, er);
      check("tmo_req_cycles", req_cycles - req0, 4);
      check("tmo_latency",    lat, 6);
      check("tmo_err",        er, 1);
      check("tmo_rdata",      rd, 8'hFF);
      check("tmo_no_we",      we_cnt - we0, 0);
      check("tmo_miss_cnt",   miss_cnt, 2);

      // 4b: ack in the expiry cycle wins.
      ack_at   = 4;
      mem_data = 8'h5A;
      we0 = we_cnt;
      do_req("tmo_edge", 1'b0, 16'h4002, 8'h00, lat, rd, er);
      check("tmo_edge_latency", lat, 7);
      check("tmo_edge_err",     er, 0);
      check("tmo_edge_rdata",   rd, 8'h5A);
      check("tmo_edge_we",      we_cnt - we0, 1);

      // 5: reset while waiting in MEM_RD.
      ack_at = 0;
      @(negedge clk_1);
      cpu.req  = 1'b1;
      cpu.wr   = 1'b0;
      cpu.addr = 16'h6000;
      repeat (2) @(negedge clk_1);
      check("rstmid_mem_req_before", mem.req, 1);
      ack0 = ack_cnt;
      we0  = we_cnt;
      rst     = 1'b1;
      cpu.req = 1'b0;
      @(negedge clk_1);
      check("rstmid_mem_req_after", mem.req, 0);
      check("rstmid_hit_cnt",  hit_cnt, 0);
      check("rstmid_miss_cnt", miss_cnt, 0);
      @(negedge clk_1);
      rst = 1'b0;
      repeat (5) @(negedge clk_1);
      check("rstmid_no_ack", ack_cnt - ack0, 0);
      check("rstmid_no_we",  we_cnt - we0, 0);
      ack_at   = 1;
      mem_data = 8'h77;
      do_req("post_rst", 1'b0, 16'h6000, 8'h00, lat, rd, er);
      check("post_rst_latency",  lat, 4);
      check("post_rst_rdata",    rd, 8'h77);
      check("post_rst_miss_cnt", miss_cnt, 1);

      // 6: hit counter saturation from a preloaded 0xFFFE.
      @(negedge clk_1);
      force dut.hit_cnt = 16'hFFFE;
      @(negedge clk_1);
      release dut.hit_cnt;
      check("sat_preload", hit_cnt, 16'hFFFE);
      do_req("sat1", 1'b0, 16'h0081, 8'h00, lat, rd, er);
      check("sat1_hit_cnt", hit_cnt, 16'hFFFF);
      do_req("sat2", 1'b0, 16'h0081, 8'h00, lat, rd, er);
      check("sat2_hit_cnt", hit_cnt, 16'hFFFF);
      do_req("sat3", 1'b0, 16'h0081, 8'h00, lat, rd, er);
      check("sat3_hit_cnt", hit_cnt, 16'hFFFF);
      check("sat3_rdata",   rd, 8'h69);

      // Back-to-back: cpu_req held high across two hit completions.
      first_ack  = -1;
      second_ack = -1;
      @(negedge clk_1);
      cpu.req  = 1'b1;
      cpu.wr   = 1'b0;
      cpu.addr = 16'h0081;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_1);
         if (cpu.ack) begin
            if (first_ack < 0) first_ack = cyc;
            else begin
               second_ack = cyc;
               break;
            end
         end
      end
      cpu.req = 1'b0;
      check("b2b_two_acks", 32'(second_ack >= 0), 32'd1);
      check("b2b_spacing",  32'(second_ack - first_ack), 32'd3);
      check("b2b_hit_cnt",  hit_cnt, 16'hFFFF);
      check("b2b_miss_cnt", miss_cnt, 1);

      repeat (3) @(negedge clk_1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound in case the stimulus itself stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

endmodule
